// File: rtl/sched_pkg.sv
// Shared scheduler definitions: default sizing for the issue scoreboard and
// the issue-control state encoding.
package sched_pkg;

  localparam int NREG_DEF  = 33;  // tracked architectural registers
  localparam int REG_W_DEF = 6;   // register index width
  localparam int CNT_W_DEF = 2;   // outstanding writes per register
  localparam int NSRC      = 3;   // source operands per micro-op

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: saturating up/down count of writes still in flight to
// a single register, with a busy flag while any write is outstanding.
module sb_entry
  import sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  // Simultaneous inc and dec cancel; both ends saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = |cnt;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks outstanding register writes, holds back
// micro-ops with RAW/WAW hazards, and drains the pipeline for serializing
// micro-ops and flushes.
//
// state | meaning
// RUN   | normal issue, hazards checked against registered counters
// DRAIN | issue blocked until every outstanding write has retired
module issue_scoreboard
  import sched_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NSRC-1:0]       src_en,
  input  logic [NSRC*REG_W-1:0] src_reg,
  input  logic                  dst_en,
  input  logic [REG_W-1:0]      dst_reg,
  input  logic                  serialize,
  output logic                  in_ready,
  input  logic                  wb_valid,
  input  logic [REG_W-1:0]      wb_reg,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_vec,
  output logic [6:0]            inflight,
  output logic [15:0]           stall_cnt,
  output logic                  err
);

  sb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             src_busy;
  logic             dst_full;
  logic             issue;
  logic             inc_any;
  logic             dec_any;

  // Indices beyond the tracked range are never busy and never counted.
  function automatic logic tracked(input logic [REG_W-1:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // Source hazard check reads only registered busy bits, so a writeback in
  // the same cycle cannot release a waiting source.
  always_comb begin
    src_busy = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_en[i] && tracked(src_reg[i*REG_W +: REG_W]) &&
          busy_vec[src_reg[i*REG_W +: REG_W]]) begin
        src_busy = 1'b1;
      end
    end
  end

  assign dst_full = dst_en && tracked(dst_reg) && (cnt[dst_reg] == '1);

  assign in_ready = reset && in_valid && (state_q == RUN) && !flush &&
                    !src_busy && !dst_full && (!serialize || (inflight == 7'd0));
  assign issue    = in_ready;

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    assign inc_vec[r] = issue && dst_en && (dst_reg == REG_W'(r));
    assign dec_vec[r] = wb_valid && (wb_reg == REG_W'(r)) && busy_vec[r];

    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk  (clk),
      .reset(reset),
      .inc  (inc_vec[r]),
      .dec  (dec_vec[r]),
      .cnt  (cnt[r]),
      .busy (busy_vec[r])
    );
  end

  assign inc_any = |inc_vec;
  assign dec_any = |dec_vec;

  // Next-state: a flush or an issued serializing op forces a drain; the drain
  // ends once nothing is in flight and no new flush is pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush || (issue && serialize)) state_d = DRAIN;
      DRAIN:   if ((inflight == 7'd0) && !flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Total outstanding writes; issue and retire in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 7'd0;
    end else if (inc_any && !dec_any) begin
      inflight <= inflight + 7'd1;
    end else if (dec_any && !inc_any) begin
      inflight <= inflight - 7'd1;
    end
  end

  // Saturating count of offered-but-held cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Sticky error: a writeback that found no outstanding write to retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (wb_valid && !dec_any) begin
      err <= 1'b1;
    end
  end

endmodule
